// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a small in-order instruction queue.
//
// Issues one outstanding 16-bit-aligned fetch at a time, buffers returned
// words with their addresses in a DEPTH-entry FIFO and presents the head to
// decode. A redirect (sel_pc==2'b01) flushes the queue and restarts fetch at
// branch_pc; a request already in flight is completed on the bus and its data
// thrown away.
//
// Optional feature (macro FETCH_QUEUE_STATS_EN): adds output starve_cnt, a
// saturating count of cycles where a fetch is in progress but decode has
// nothing to consume.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   sel_pc          2'b01 = redirect to branch_pc, otherwise sequential
//   branch_pc       redirect target
//   decode_stall    decode refuses the head instruction this cycle
//   mem_ack         mem_rdata valid for the outstanding request
//   mem_rdata       returned instruction word
//   mem_req         fetch request outstanding
//   mem_addr        byte address of the outstanding request
//   inst_code       head instruction word
//   inst_pc         head instruction address
//   inst_valid      head entry valid (queue non-empty)
//   starve_cnt      (FETCH_QUEUE_STATS_EN only) starvation cycle counter
//
// DEPTH must be 2, 4 or 8 (power of two so the pointers wrap naturally).

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h000C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sel_pc,
  input  logic [15:0] branch_pc,
  input  logic        decode_stall,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] inst_code,
  output logic [15:0] inst_pc,
`ifdef FETCH_QUEUE_STATS_EN
  output logic [15:0] starve_cnt,
`endif
  output logic        inst_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} fetchState_t;

  fetchState_t state, stateNext;

  logic [15:0]   qPc   [DEPTH];
  logic [15:0]   qCode [DEPTH];
  logic [AW-1:0] headPtr, tailPtr;
  logic [CW-1:0] count, countNext;
  logic [15:0]   fetchPc, fetchPcNext;
  logic [15:0]   reqAddr;

  logic redirect, pop, push, issue;

  assign redirect = (sel_pc == 2'b01);
  assign pop      = inst_valid && !decode_stall;
  // Data is only kept when we still want it: not in DROP, not on a redirect.
  assign push     = (state == REQ) && mem_ack && !redirect;

  // Occupancy after this cycle's flush/push/pop; drives the issue decision
  // so a new request is only made when its data is guaranteed a slot.
  always_comb begin
    countNext = count;
    if (redirect) countNext = '0;
    else          countNext = count + CW'(push) - CW'(pop);
  end

  always_comb begin
    fetchPcNext = fetchPc;
    if (redirect)  fetchPcNext = branch_pc;
    else if (push) fetchPcNext = fetchPc + 16'd2;
  end

  // Next-state logic. A redirect flushes the queue (countNext==0), so the
  // "space available" tests below also cover the redirect cases.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = (countNext < CW'(DEPTH)) ? REQ : IDLE;
      REQ: begin
        if (mem_ack)       stateNext = (countNext < CW'(DEPTH)) ? REQ : IDLE;
        else if (redirect) stateNext = DROP;
        else               stateNext = REQ;
      end
      DROP:    stateNext = mem_ack ? REQ : DROP;
      default: stateNext = IDLE;
    endcase
  end

  // A fresh request starts whenever we land in REQ from anywhere other than
  // a REQ that is still waiting; its address is latched so mem_addr stays
  // put even if fetchPc moves (redirect while the old request drains).
  assign issue = (stateNext == REQ) && ((state != REQ) || mem_ack);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= REQ;
      reqAddr <= RESET_PC;
      fetchPc <= RESET_PC;
      count   <= '0;
      headPtr <= '0;
      tailPtr <= '0;
    end else begin
      state   <= stateNext;
      fetchPc <= fetchPcNext;
      count   <= countNext;
      if (issue) reqAddr <= fetchPcNext;
      if (redirect) begin
        headPtr <= '0;
        tailPtr <= '0;
      end else begin
        if (pop)  headPtr <= headPtr + AW'(1);
        if (push) tailPtr <= tailPtr + AW'(1);
      end
    end
  end

  // Queue storage needs no reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      qPc[tailPtr]   <= mem_addr;
      qCode[tailPtr] <= mem_rdata;
    end
  end

  // Outputs. mem_req is masked during reset so the request pending from
  // reset only appears once reset drops.
  always_comb begin
    mem_req    = (state != IDLE) && !reset;
    mem_addr   = reqAddr;
    inst_valid = (count != '0);
    inst_pc    = qPc[headPtr];
    inst_code  = qCode[headPtr];
  end

`ifdef FETCH_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      starve_cnt <= '0;
    else if (!inst_valid && (state != IDLE) && (starve_cnt != 16'hFFFF))
      starve_cnt <= starve_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel_pc;
  logic [15:0] branch_pc;
  logic        decode_stall;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] inst_code;
  logic [15:0] inst_pc;
  logic        inst_valid;
`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] starve_cnt;
`endif

  logic autoAck, manAck;
  int   passCnt = 0;
  int   totalCnt = 0;

  always #5 clk = ~clk;

  // Memory model: either acks every request in its first cycle, or is driven
  // by hand. Data is a fixed scramble of the address.
  assign mem_ack   = autoAck ? mem_req : manAck;
  assign mem_rdata = mem_addr ^ 16'hA5A5;

  fetch_queue #(.DEPTH(4), .RESET_PC(16'h000C)) dut (
    .clk(clk), .reset(reset), .sel_pc(sel_pc), .branch_pc(branch_pc),
    .decode_stall(decode_stall), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .inst_code(inst_code),
    .inst_pc(inst_pc),
`ifdef FETCH_QUEUE_STATS_EN
    .starve_cnt(starve_cnt),
`endif
    .inst_valid(inst_valid)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then sampled mid-cycle at the negedge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1; manAck = 1'b0; sel_pc = 2'b00;
    cyc(); cyc();
    chk("rst_mem_req", 16'(mem_req), 16'h0);
    chk("rst_valid", 16'(inst_valid), 16'h0);
    reset = 1'b0;
    #1;
    chk("rel_mem_req", 16'(mem_req), 16'h1);
    chk("rel_mem_addr", mem_addr, 16'h000C);
  endtask

  initial begin
    reset = 1'b1; sel_pc = 2'b00; branch_pc = 16'h0; decode_stall = 1'b0;
    autoAck = 1'b1; manAck = 1'b0;
    cyc();

    // Streaming with immediate acks, decode always ready
    doReset();
    chk("s1_valid0", 16'(inst_valid), 16'h0);
    cyc();
    chk("s1_valid1", 16'(inst_valid), 16'h1);
    chk("s1_pc0", inst_pc, 16'h000C);
    chk("s1_code0", inst_code, 16'h000C ^ 16'hA5A5);
    chk("s1_addr1", mem_addr, 16'h000E);
    cyc();
    chk("s1_addr2", mem_addr, 16'h0010);
    chk("s1_pc1", inst_pc, 16'h000E);
    cyc();
    chk("s1_addr3", mem_addr, 16'h0012);
    chk("s1_pc2", inst_pc, 16'h0010);

    // Decode stalled: queue fills to DEPTH then fetching stops
    decode_stall = 1'b1;
    doReset();
    cyc(); cyc(); cyc();
    chk("s2_req_before_full", 16'(mem_req), 16'h1);
    chk("s2_addr3", mem_addr, 16'h0012);
    cyc();
    chk("s2_full_req", 16'(mem_req), 16'h0);
    chk("s2_head", inst_pc, 16'h000C);
    cyc(); cyc();
    chk("s2_hold_req", 16'(mem_req), 16'h0);
    chk("s2_hold_head", inst_pc, 16'h000C);
    decode_stall = 1'b0;
    cyc();
    chk("s2_pop1", inst_pc, 16'h000E);
    chk("s2_resume_req", 16'(mem_req), 16'h1);
    chk("s2_resume_addr", mem_addr, 16'h0014);
    cyc();
    chk("s2_pop2", inst_pc, 16'h0010);
    chk("s2_addr", mem_addr, 16'h0016);
    cyc();
    chk("s2_pop3", inst_pc, 16'h0012);

    // Redirect while a request is waiting for a slow ack
    doReset();
    cyc(); cyc(); cyc(); cyc();
    chk("s3_pending", mem_addr, 16'h0014);
    autoAck = 1'b0; manAck = 1'b0;
    sel_pc = 2'b01; branch_pc = 16'h0040;
    cyc();
    sel_pc = 2'b00;
    chk("s3_drop_addr", mem_addr, 16'h0014);
    chk("s3_drop_req", 16'(mem_req), 16'h1);
    chk("s3_flush", 16'(inst_valid), 16'h0);
    cyc(); cyc();
    chk("s3_drop_addr2", mem_addr, 16'h0014);
    chk("s3_flush2", 16'(inst_valid), 16'h0);
    manAck = 1'b1;
    cyc();
    manAck = 1'b0;
    chk("s3_new_addr", mem_addr, 16'h0040);
    chk("s3_discard", 16'(inst_valid), 16'h0);
    autoAck = 1'b1;
    cyc();
    chk("s3_first_pc", inst_pc, 16'h0040);
    chk("s3_first_valid", 16'(inst_valid), 16'h1);

    // Redirect coincident with an ack
    chk("s4_pending", mem_addr, 16'h0042);
    sel_pc = 2'b01; branch_pc = 16'h0080;
    cyc();
    sel_pc = 2'b00;
    chk("s4_flush", 16'(inst_valid), 16'h0);
    chk("s4_addr", mem_addr, 16'h0080);
    cyc();
    chk("s4_pc", inst_pc, 16'h0080);
    chk("s4_next_addr", mem_addr, 16'h0082);

    // Address wrap at the top of memory
    sel_pc = 2'b01; branch_pc = 16'hFFFE;
    cyc();
    sel_pc = 2'b00;
    chk("s5_addr_fffe", mem_addr, 16'hFFFE);
    cyc();
    chk("s5_addr_wrap", mem_addr, 16'h0000);
    chk("s5_pc_fffe", inst_pc, 16'hFFFE);
    cyc();
    chk("s5_pc_wrap", inst_pc, 16'h0000);

    // Redirect while idle on a full queue
    decode_stall = 1'b1;
    doReset();
    cyc(); cyc(); cyc(); cyc();
    chk("s6_idle", 16'(mem_req), 16'h0);
    sel_pc = 2'b01; branch_pc = 16'h0100;
    cyc();
    sel_pc = 2'b00;
    chk("s6_flush", 16'(inst_valid), 16'h0);
    chk("s6_req", 16'(mem_req), 16'h1);
    chk("s6_addr", mem_addr, 16'h0100);
    decode_stall = 1'b0;

    // Reset in the middle of a request, with an ack during reset
    autoAck = 1'b0; manAck = 1'b0;
    cyc();
    reset = 1'b1; manAck = 1'b1;
    cyc();
    chk("s7_rst_valid", 16'(inst_valid), 16'h0);
    chk("s7_rst_req", 16'(mem_req), 16'h0);
    cyc();
    chk("s7_rst_valid2", 16'(inst_valid), 16'h0);
    reset = 1'b0; manAck = 1'b0;
    #1;
    chk("s7_rel_addr", mem_addr, 16'h000C);
    autoAck = 1'b1;
    cyc();
    chk("s7_pc", inst_pc, 16'h000C);

`ifdef FETCH_QUEUE_STATS_EN
    // Slow first ack: starvation counted every cycle before data arrives
    autoAck = 1'b0;
    doReset();
    chk("st_zero", starve_cnt, 16'd0);
    cyc(); cyc(); cyc(); cyc(); cyc();
    chk("st_five", starve_cnt, 16'd5);
    chk("st_novalid", 16'(inst_valid), 16'h0);
    manAck = 1'b1;
    cyc();
    manAck = 1'b0;
    chk("st_valid", 16'(inst_valid), 16'h1);
    chk("st_six", starve_cnt, 16'd6);
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
